sample_averager: RTL

SAMPLE_AVERAGER -- requirements
Module: sample_averager

---
 rtl/avg_pkg.sv | 14 +
 rtl/avg_chan.sv | 47 ++++
 rtl/sample_averager.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/avg_pkg.sv
// Shared types and widths for the sample averager: FSM states, depth width, overrun counter width.
package avg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  localparam int unsigned DEPTH_W   = 4;
  localparam int unsigned OVR_CNT_W = 16;

endpackage

// File: rtl/avg_chan.sv
// One averaging channel: zero-extended accumulate, clear, and shift-truncate into a held result.
module avg_chan
  import avg_pkg::*;
#(
  parameter int unsigned sig_width = 12,
  parameter int unsigned acc_width = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 add,
  input  logic                 load,
  input  logic [sig_width-1:0] sample,
  input  logic [DEPTH_W-1:0]   shift,
  output logic [sig_width-1:0] result
);

  logic [acc_width-1:0] acc_q, acc_d;
  logic [sig_width-1:0] result_q, result_d;

  // Clear wins over add so a discarded sample never leaks into the next frame
  always_comb begin
    acc_d    = acc_q;
    result_d = result_q;
    if (clr) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = acc_q + acc_width'(sample);
    end
    if (load) begin
      result_d = sig_width'(acc_q >> shift);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/sample_averager.sv
// Two-channel power-of-two sample averager with run control and overrun tracking.
// Define AVG_OVERRUN_CNT_EN to build the saturating dropped-sample counter.
module sample_averager
  import avg_pkg::*;
#(
  parameter int unsigned sig_width = 12,
  parameter int unsigned max_log2  = 10,
  parameter int unsigned acc_width = sig_width + max_log2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 filt_done,
  input  logic [sig_width-1:0] filt_out_a,
  input  logic [sig_width-1:0] filt_out_b,
  input  logic                 cfg_ready,
  input  logic [DEPTH_W-1:0]   avg_log2_i,
  output logic                 cfg_done,
  output logic [DEPTH_W-1:0]   avg_log2,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cont,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [sig_width-1:0] out_a,
  output logic [sig_width-1:0] out_b,
  output logic                 overrun,
  output logic [OVR_CNT_W-1:0] overrun_cnt
);

  localparam int unsigned CNT_W = max_log2 + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH_W-1:0] avg_log2_q, avg_log2_d;
  logic               cfg_done_q, cfg_done_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;
  logic               stop_seen_q, stop_seen_d;

  logic               acc_clr_c, acc_add_c, out_load_c, drop_c;
  logic [CNT_W-1:0]   target_c, count_inc_c;

  assign target_c    = CNT_W'(1) << avg_log2_q;
  assign count_inc_c = count_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    avg_log2_d  = avg_log2_q;
    cfg_done_d  = 1'b0;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    stop_seen_d = stop_seen_q;
    acc_clr_c   = 1'b0;
    acc_add_c   = 1'b0;
    out_load_c  = 1'b0;
    drop_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_ready) begin
          avg_log2_d = (avg_log2_i > DEPTH_W'(max_log2)) ? DEPTH_W'(max_log2) : avg_log2_i;
          cfg_done_d = 1'b1;
        end
        if (start) begin
          state_d     = ACCUM;
          acc_clr_c   = 1'b1;
          count_d     = '0;
          stop_seen_d = 1'b0;
        end
      end
      ACCUM: begin
        if (stop) begin
          state_d   = IDLE;
          acc_clr_c = 1'b1;
          count_d   = '0;
        end else if (filt_done) begin
          acc_add_c = 1'b1;
          count_d   = count_inc_c;
          if (count_inc_c == target_c) begin
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        out_load_c  = 1'b1;
        out_valid_d = 1'b1;
        state_d     = OUTPUT;
        drop_c      = filt_done;
        if (stop) stop_seen_d = 1'b1;
      end
      OUTPUT: begin
        drop_c = filt_done;
        if (stop) stop_seen_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          stop_seen_d = 1'b0;
          count_d     = '0;
          if (cont && !stop_seen_q && !stop) begin
            state_d   = ACCUM;
            acc_clr_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop_c) overrun_d = 1'b1;

    // Flush overrides everything except the configured depth
    if (flush) begin
      state_d     = IDLE;
      count_d     = '0;
      cfg_done_d  = 1'b0;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
      stop_seen_d = 1'b0;
      acc_clr_c   = 1'b1;
      acc_add_c   = 1'b0;
      out_load_c  = 1'b0;
      drop_c      = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      avg_log2_q  <= '0;
      cfg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      avg_log2_q  <= avg_log2_d;
      cfg_done_q  <= cfg_done_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      stop_seen_q <= stop_seen_d;
    end
  end

`ifdef AVG_OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

  // Saturating count of dropped samples
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (flush) begin
      ovr_cnt_d = '0;
    end else if (drop_c && (ovr_cnt_q != {OVR_CNT_W{1'b1}})) begin
      ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_cnt_q <= '0;
    else     ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_cnt = ovr_cnt_q;
`else
  assign overrun_cnt = '0;
`endif

  avg_chan #(.sig_width(sig_width), .acc_width(acc_width)) u_chan_a (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr_c),
    .add    (acc_add_c),
    .load   (out_load_c),
    .sample (filt_out_a),
    .shift  (avg_log2_q),
    .result (out_a)
  );

  avg_chan #(.sig_width(sig_width), .acc_width(acc_width)) u_chan_b (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr_c),
    .add    (acc_add_c),
    .load   (out_load_c),
    .sample (filt_out_b),
    .shift  (avg_log2_q),
    .result (out_b)
  );

  assign cfg_done  = cfg_done_q;
  assign avg_log2  = avg_log2_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
